// File: rtl/div_unit.sv
// div_unit: iterative integer divider with register-file writeback.
//
// Radix-2 restoring divide on operand magnitudes, one quotient bit per cycle,
// with sign fix-up applied once the magnitudes are done. The result is held in
// DONE until the register-file write port is granted.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - synchronous active-high reset
//   start        - begin a divide (accepted only while idle)
//   op[1:0]      - op[0]: 1 signed / 0 unsigned; op[1]: 1 remainder / 0 quotient
//   rd_in        - destination register index of the request
//   src0, src1   - dividend, divisor
//   wb_ready     - register-file write port granted this cycle
//   flush        - cancel any in-flight operation
//   busy         - high whenever not idle
//   RFWrite      - register-file write enable
//   rd           - register-file write index
//   rd_WriteData - register-file write data
module div_unit #(
    parameter int unsigned WORD    = 32,
    parameter int unsigned REG_LOG = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [REG_LOG-1:0] rd_in,
    input  logic [WORD-1:0]    src0,
    input  logic [WORD-1:0]    src1,
    input  logic               wb_ready,
    input  logic               flush,
    output logic               busy,
    output logic               RFWrite,
    output logic [REG_LOG-1:0] rd,
    output logic [WORD-1:0]    rd_WriteData
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WORD-1:0]    rem_q, rem_d;      // partial remainder
    logic [WORD-1:0]    quo_q, quo_d;      // dividend shifting out, quotient shifting in
    logic [WORD-1:0]    dvsr_q, dvsr_d;    // divisor magnitude
    logic               rem_sel_q, rem_sel_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic [REG_LOG-1:0] rd_lat_q, rd_lat_d;
    logic               wr_q, wr_d;
    logic [REG_LOG-1:0] rd_q, rd_d;
    logic [WORD-1:0]    data_q, data_d;

    logic               a_neg, b_neg;
    logic [WORD-1:0]    a_mag, b_mag;
    logic [WORD:0]      shifted;
    logic               ge;
    logic [WORD-1:0]    sub;
    logic [WORD-1:0]    quo_res, rem_res;

    always_comb begin
        a_neg = op[0] & src0[WORD-1];
        b_neg = op[0] & src1[WORD-1];
        a_mag = a_neg ? ({WORD{1'b0}} - src0) : src0;
        b_mag = b_neg ? ({WORD{1'b0}} - src1) : src1;

        // One restoring step: bring down the next dividend bit, subtract if it fits.
        shifted = {rem_q, quo_q[WORD-1]};
        ge      = shifted >= {1'b0, dvsr_q};
        sub     = WORD'(shifted - {1'b0, dvsr_q});

        // A zero divisor leaves an all-ones magnitude quotient, which must not be
        // sign-corrected; the remainder magnitude is |dividend| and regains its sign.
        quo_res = dz_q      ? {WORD{1'b1}} :
                  quo_neg_q ? ({WORD{1'b0}} - quo_q) : quo_q;
        rem_res = rem_neg_q ? ({WORD{1'b0}} - rem_q) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        rem_sel_d = rem_sel_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        rd_lat_d  = rd_lat_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        data_d    = data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCalc;
                    cnt_d     = 6'd0;
                    rem_d     = {WORD{1'b0}};
                    quo_d     = a_mag;
                    dvsr_d    = b_mag;
                    rem_sel_d = op[1];
                    quo_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dz_d      = (src1 == {WORD{1'b0}});
                    rd_lat_d  = rd_in;
                end
            end
            StCalc: begin
                if (cnt_q != 6'(WORD)) begin
                    rem_d = ge ? sub : shifted[WORD-1:0];
                    quo_d = {quo_q[WORD-2:0], ge};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    // All quotient bits are in; apply signs and present the result.
                    state_d = StDone;
                    wr_d    = 1'b1;
                    rd_d    = rd_lat_q;
                    data_d  = rem_sel_q ? rem_res : quo_res;
                end
            end
            StDone: begin
                if (wb_ready) begin
                    state_d = StIdle;
                    wr_d    = 1'b0;
                    rd_d    = {REG_LOG{1'b0}};
                    data_d  = {WORD{1'b0}};
                end
            end
            default: state_d = StIdle;
        endcase

        // Cancel wins over start and wb_ready.
        if (flush) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
            wr_d    = 1'b0;
            rd_d    = {REG_LOG{1'b0}};
            data_d  = {WORD{1'b0}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            rem_q     <= {WORD{1'b0}};
            quo_q     <= {WORD{1'b0}};
            dvsr_q    <= {WORD{1'b0}};
            rem_sel_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            rd_lat_q  <= {REG_LOG{1'b0}};
            wr_q      <= 1'b0;
            rd_q      <= {REG_LOG{1'b0}};
            data_q    <= {WORD{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            rem_sel_q <= rem_sel_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            rd_lat_q  <= rd_lat_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign RFWrite      = wr_q;
    assign rd           = rd_q;
    assign rd_WriteData = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors with literal expectations,
// plus a transaction-level reference model compared on every cycle.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, wb_ready, flush;
    logic [1:0]  op;
    logic [4:0]  rd_in;
    logic [31:0] src0, src1;
    logic        busy, RFWrite;
    logic [4:0]  rd;
    logic [31:0] rd_WriteData;

    int checks = 0;
    int errors = 0;

    div_unit #(.WORD(32), .REG_LOG(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rd_in(rd_in),
        .src0(src0), .src1(src1), .wb_ready(wb_ready), .flush(flush),
        .busy(busy), .RFWrite(RFWrite), .rd(rd), .rd_WriteData(rd_WriteData)
    );

    always #5 clk = ~clk;

    // Arithmetic definition of every op, straight from the operation rules.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? a % b : a / b;
    endfunction

    // Transaction model: idle / computing for 33 edges / holding result.
    int          m_phase = 0;  // 0 idle, 1 computing, 2 result held
    int          m_age   = 0;
    logic [31:0] m_res   = '0;
    logic [4:0]  m_rd    = '0;
    bit          chk_en  = 1'b0;

    always @(posedge clk) begin
        if (rst || flush) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                m_age   = 0;
                m_res   = ref_div(op, src0, src1);
                m_rd    = rd_in;
            end
        end else if (m_phase == 1) begin
            m_age++;
            if (m_age == 33) m_phase = 2;
        end else if (wb_ready) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== (m_phase != 0) || RFWrite !== (m_phase == 2) ||
                rd !== ((m_phase == 2) ? m_rd : 5'd0) ||
                rd_WriteData !== ((m_phase == 2) ? m_res : 32'd0)) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got busy=%b wr=%b rd=%0d data=%h, expected busy=%b wr=%b rd=%0d data=%h",
                         $time, busy, RFWrite, rd, rd_WriteData, (m_phase != 0),
                         (m_phase == 2), (m_phase == 2) ? m_rd : 5'd0,
                         (m_phase == 2) ? m_res : 32'd0);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one divide, check latency, result and write index, then retire it.
    // hold: DONE cycles with wb_ready low; keep_start: leave start asserted throughout.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                          input int hold, input bit keep_start);
        int  e;
        bit  found;
        logic [31:0] held;
        @(negedge clk);
        op = o; src0 = a; src1 = b; rd_in = r; start = 1'b1;
        wb_ready = (hold == 0);
        @(posedge clk);                       // edge 0: accepted
        @(negedge clk);
        start = keep_start;
        src0 = 32'hDEAD_BEEF; src1 = 32'h1234_5678; op = ~o; rd_in = ~r;
        e = 0;
        found = 1'b0;
        while (!found && e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (RFWrite) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no write within 40 edges, expected write after edge 33", name);
            start = 1'b0;
            wb_ready = 1'b1;
            return;
        end
        check({name, "_latency"}, 32'(e), 32'd33);
        check({name, "_data"}, rd_WriteData, exp);
        check({name, "_rd"}, 32'(rd), 32'(r));
        held = rd_WriteData;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_hold_wr"}, 32'(RFWrite), 32'd1);
            check({name, "_hold_busy"}, 32'(busy), 32'd1);
            check({name, "_hold_data"}, rd_WriteData, held);
        end
        wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({name, "_retire_busy"}, 32'(busy), 32'd0);
        check({name, "_retire_wr"}, 32'(RFWrite), 32'd0);
    endtask

    // Start a divide, cancel it at edge k with flush (use_rst=0) or rst (use_rst=1).
    task automatic cancel_op(input string name, input int k, input bit use_rst);
        bit seen;
        @(negedge clk);
        op = 2'b00; src0 = 32'd50; src1 = 32'd3; rd_in = 5'd9; start = 1'b1; wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (k - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        start = 1'b1;                         // must lose to the cancel
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_wr"}, 32'(RFWrite), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (RFWrite) seen = 1'b1;
        end
        check({name, "_no_write"}, 32'(seen), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        op = 2'b00; rd_in = 5'd0; src0 = 32'd0; src1 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr", 32'(RFWrite), 32'd0);
        check("reset_rd", 32'(rd), 32'd0);
        check("reset_data", rd_WriteData, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op("udiv",     2'b00, 32'd100,        32'd7,          5'd5,  32'd14,         0, 1'b0);
        run_op("urem",     2'b10, 32'd100,        32'd7,          5'd5,  32'd2,          0, 1'b0);
        run_op("sdiv",     2'b01, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  0, 1'b0);
        run_op("srem",     2'b11, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,  0, 1'b0);
        run_op("udiv0",    2'b00, 32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF,  0, 1'b0);
        run_op("srem0",    2'b11, 32'd5,          32'd0,          5'd7,  32'd5,          0, 1'b0);
        run_op("sdiv0neg", 2'b01, 32'hFFFF_FFF0,  32'd0,          5'd8,  32'hFFFF_FFFF,  0, 1'b0);
        run_op("srem0neg", 2'b11, 32'hFFFF_FFF0,  32'd0,          5'd8,  32'hFFFF_FFF0,  0, 1'b0);
        run_op("sdiv_ovf", 2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd31, 32'h8000_0000,  0, 1'b0);
        run_op("srem_ovf", 2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  5'd31, 32'd0,          0, 1'b0);
        run_op("udiv_big", 2'b00, 32'hFFFF_FFFF,  32'd3,          5'd1,  32'h5555_5555,  0, 1'b0);
        run_op("urem_big", 2'b10, 32'hFFFF_FFFF,  32'd10,         5'd2,  32'd5,          0, 1'b0);
        run_op("sdiv_nn",  2'b01, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd4,  32'd14,         0, 1'b0);
        run_op("backpres", 2'b00, 32'd1000,       32'd10,         5'd12, 32'd100,        3, 1'b1);

        cancel_op("flush10", 10, 1'b0);
        run_op("after_flush", 2'b00, 32'd7,  32'd7, 5'd0, 32'd1,         0, 1'b0);
        cancel_op("rst20", 20, 1'b1);
        run_op("after_rst",   2'b01, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFF2, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide parameter WORD, default 32, datapath width in bits.
REQ-002 SHALL provide parameter REG_LOG, default 5, register index width in bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin a divide; accepted only when busy=0.
REQ-006 SHALL have port op, input, 2, operation select: op[0]=1 signed, 0 unsigned; op[1]=1 remainder, 0 quotient.
REQ-007 SHALL have port rd_in, input, REG_LOG, destination register index of the request.
REQ-008 SHALL have port src0, input, WORD, dividend, read from the register file.
REQ-009 SHALL have port src1, input, WORD, divisor, read from the register file.
REQ-010 SHALL have port wb_ready, input, 1, the register file write port is granted to this unit this cycle.
REQ-011 SHALL have port flush, input, 1, cancels any in-flight operation.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port RFWrite, output, 1, register file write enable.
REQ-014 SHALL have port rd, output, REG_LOG, register file write index.
REQ-015 SHALL have port rd_WriteData, output, WORD, register file write data.

Function
REQ-016 SHALL implement states IDLE, CALC and DONE.
REQ-017 IDLE->CALC on any edge with start=1 and flush=0; SHALL latch op, rd_in, src0 and src1 at that edge.
REQ-018 In CALC, SHALL run a radix-2 restoring divide on magnitudes, one quotient bit per cycle, for exactly WORD cycles, using a 6-bit iteration counter.
REQ-019 SHALL enter DONE on the edge that completes iteration WORD; with the accepting edge as edge 0, RFWrite SHALL first be high after edge WORD+1 (edge 33 for WORD=32).
REQ-020 In DONE, SHALL hold RFWrite=1 and keep rd and rd_WriteData stable until an edge with wb_ready=1, then go to IDLE with RFWrite=0.
REQ-021 In IDLE and CALC, SHALL drive RFWrite=0, rd=0 and rd_WriteData=0.
REQ-022 Signed ops: quotient SHALL be negated when operand signs differ; remainder SHALL take the dividend's sign.
REQ-023 Divisor 0, all ops: quotient SHALL be all-ones and remainder SHALL be the dividend, with unchanged latency.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF: quotient SHALL be 0x80000000 and remainder 0.
REQ-025 start while busy=1 SHALL be ignored, including in the DONE cycle that retires a result.
REQ-026 flush=1 SHALL force IDLE at that edge from any state, with RFWrite=0 afterwards; it SHALL take priority over start and wb_ready in the same cycle.
REQ-027 rd_in=0 SHALL be processed normally; no write suppression (the register file ignores writes to r0).

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, clear the counter and latched operands, and drive busy=0, RFWrite=0, rd=0 and rd_WriteData=0; it SHALL take priority over flush and start.
REQ-029 Reset asserted mid-CALC or in DONE SHALL discard the operation; no write SHALL occur afterwards.

Verification
REQ-030 Unsigned: op=00, src0=100, src1=7, rd_in=5, wb_ready=1 -> RFWrite pulses one cycle after edge 33, rd=5, data=14; repeat with op=10 -> data=2.
REQ-031 Signed: op=01, src0=0xFFFFFFF9 (-7), src1=2 -> data=0xFFFFFFFD; op=11 -> data=0xFFFFFFFF.
REQ-032 Divide by zero: op=00, src0=5, src1=0 -> 0xFFFFFFFF; op=11, src0=5, src1=0 -> 5; both at edge 33.
REQ-033 Overflow: op=01, src0=0x80000000, src1=0xFFFFFFFF -> 0x80000000; op=11 -> 0.
REQ-034 Backpressure: wb_ready=0 for 3 cycles in DONE, start=1 throughout -> RFWrite and data held stable, busy=1, start ignored; wb_ready=1 -> IDLE on the next edge.
REQ-035 Cancel: flush=1 at edge 10 of CALC, or rst=1 at edge 20 -> IDLE and busy=0 on the next cycle, RFWrite never asserted; a new start afterwards completes correctly.
